// File: rtl/rob_mw.sv
// -----------------------------------------------------------------------------
// rob_mw : circular reorder buffer with multi-lane in-order retirement
//
// Allocates one entry per dispatched instruction at the tail and records
// results broadcast on the CDB. Completed entries leave from the head in
// program order, up to RETIRE_W per cycle. A mispredicted branch reaching
// retirement flushes every younger entry.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_disp_*                dispatch request: rd, PC, type (00 ALU/LOAD,
//                           01 STORE, 10 BRANCH, 11 treated as 00)
//   o_disp_tag              tag the next accepted dispatch receives (tail)
//   o_full                  all DEPTH entries occupied
//   i_rs1_tag / i_rs2_tag   operand lookups; o_rsN_valid / o_rsN_data give
//                           the speculative value, with CDB bypass
//   i_cdb_*                 result broadcast: tag, data, mispredict flag
//   i_st_ready              store commit path can take a store this cycle
//   o_ret_*                 per-lane retire strobe / rd / data / PC / type,
//                           lane 0 is the oldest
//   o_flush                 one-cycle pulse after a mispredict retires
//   o_count                 occupied entries
// -----------------------------------------------------------------------------
module rob_mw #(
    parameter int DEPTH    = 32,
    parameter int TAG_W    = $clog2(DEPTH),
    parameter int XLEN     = 32,
    parameter int RETIRE_W = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_disp_en,
    input  logic [4:0]               i_disp_rd,
    input  logic [XLEN-1:0]          i_disp_pc,
    input  logic [1:0]               i_disp_type,
    output logic [TAG_W-1:0]         o_disp_tag,
    output logic                     o_full,
    input  logic [TAG_W-1:0]         i_rs1_tag,
    input  logic [TAG_W-1:0]         i_rs2_tag,
    output logic                     o_rs1_valid,
    output logic                     o_rs2_valid,
    output logic [XLEN-1:0]          o_rs1_data,
    output logic [XLEN-1:0]          o_rs2_data,
    input  logic                     i_cdb_valid,
    input  logic [TAG_W-1:0]         i_cdb_tag,
    input  logic [XLEN-1:0]          i_cdb_data,
    input  logic                     i_cdb_mispredict,
    input  logic                     i_st_ready,
    output logic [RETIRE_W-1:0]      o_ret_valid,
    output logic [5*RETIRE_W-1:0]    o_ret_rd,
    output logic [XLEN*RETIRE_W-1:0] o_ret_data,
    output logic [XLEN*RETIRE_W-1:0] o_ret_pc,
    output logic [2*RETIRE_W-1:0]    o_ret_type,
    output logic                     o_flush,
    output logic [TAG_W:0]           o_count
);

    localparam int PTR_W = TAG_W + 1;
    localparam logic [PTR_W-1:0] FULL_COUNT  = PTR_W'(DEPTH);
    localparam logic [1:0]       TYPE_ALU    = 2'b00;
    localparam logic [1:0]       TYPE_STORE  = 2'b01;
    localparam logic [1:0]       TYPE_BRANCH = 2'b10;

    // Pointers carry a wrap bit; only the low TAG_W bits index the entries.
    logic [PTR_W-1:0] head, tail, count;
    logic [PTR_W-1:0] head_next, tail_next, count_next, n_ret;
    logic             flush_q;

    logic [DEPTH-1:0] ent_valid, ent_done;
    logic [DEPTH-1:0] valid_next, done_next;
    logic [DEPTH-1:0] ent_mispredict;
    logic [4:0]       ent_rd   [DEPTH];
    logic [1:0]       ent_type [DEPTH];
    logic [XLEN-1:0]  ent_pc   [DEPTH];
    logic [XLEN-1:0]  ent_data [DEPTH];

    logic [RETIRE_W-1:0] ret_ok;
    logic [TAG_W-1:0]    lane_idx [RETIRE_W];
    logic                flushing;
    logic                disp_accept;
    logic                cdb_hit;
    logic [TAG_W-1:0]    tail_idx;

    assign tail_idx    = tail[TAG_W-1:0];
    assign o_disp_tag  = tail_idx;
    assign o_full      = (count == FULL_COUNT);
    assign o_count     = count;
    assign o_flush     = flush_q;
    assign cdb_hit     = i_cdb_valid && ent_valid[i_cdb_tag];
    assign disp_accept = i_disp_en && !o_full && !flushing;

    // Retire selection: walk lanes from the head and stop at the first entry
    // that cannot leave. A store is only allowed in lane 0 so the commit path
    // sees at most one store per cycle; a mispredicted branch ends the group
    // because everything behind it is wrong-path.
    always_comb begin
        logic stop;
        logic [TAG_W-1:0] idx;
        ret_ok     = '0;
        n_ret      = '0;
        flushing   = 1'b0;
        stop       = 1'b0;
        o_ret_rd   = '0;
        o_ret_data = '0;
        o_ret_pc   = '0;
        o_ret_type = '0;
        for (int k = 0; k < RETIRE_W; k++) begin
            idx         = head[TAG_W-1:0] + TAG_W'(k);
            lane_idx[k] = idx;
            if (!stop && (PTR_W'(k) < count) && ent_valid[idx] && ent_done[idx] &&
                ((ent_type[idx] != TYPE_STORE) || (k == 0 && i_st_ready))) begin
                ret_ok[k]                   = 1'b1;
                n_ret                       = PTR_W'(k + 1);
                o_ret_rd[5*k +: 5]          = ent_rd[idx];
                o_ret_data[XLEN*k +: XLEN]  = ent_data[idx];
                o_ret_pc[XLEN*k +: XLEN]    = ent_pc[idx];
                o_ret_type[2*k +: 2]        = ent_type[idx];
                if (ent_type[idx] == TYPE_BRANCH && ent_mispredict[idx]) begin
                    flushing = 1'b1;
                    stop     = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    assign o_ret_valid = ret_ok;

    // On a flush the tail snaps back to just past the retiring branch, which
    // empties the buffer without needing a drain.
    always_comb begin
        head_next  = head + n_ret;
        tail_next  = tail + PTR_W'(disp_accept);
        count_next = count + PTR_W'(disp_accept) - n_ret;
        if (flushing) begin
            tail_next  = head_next;
            count_next = '0;
        end
    end

    // Entry status update. Later assignments win: retirement clears what the
    // CDB may have just marked, dispatch claims a free slot, flush clears all.
    always_comb begin
        valid_next = ent_valid;
        done_next  = ent_done;
        if (cdb_hit) begin
            done_next[i_cdb_tag] = 1'b1;
        end
        for (int k = 0; k < RETIRE_W; k++) begin
            if (ret_ok[k]) begin
                valid_next[lane_idx[k]] = 1'b0;
                done_next[lane_idx[k]]  = 1'b0;
            end
        end
        if (disp_accept) begin
            valid_next[tail_idx] = 1'b1;
            done_next[tail_idx]  = 1'b0;
        end
        if (flushing) begin
            valid_next = '0;
            done_next  = '0;
        end
    end

    // Control state and status bits, cleared by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            flush_q   <= 1'b0;
            ent_valid <= '0;
            ent_done  <= '0;
        end else begin
            head      <= head_next;
            tail      <= tail_next;
            count     <= count_next;
            flush_q   <= flushing;
            ent_valid <= valid_next;
            ent_done  <= done_next;
        end
    end

    // Entry payload needs no reset; it is only observed through valid/done.
    always_ff @(posedge i_clk) begin
        if (disp_accept) begin
            ent_rd[tail_idx]   <= i_disp_rd;
            ent_type[tail_idx] <= (i_disp_type == 2'b11) ? TYPE_ALU : i_disp_type;
            ent_pc[tail_idx]   <= i_disp_pc;
        end
        if (cdb_hit) begin
            ent_data[i_cdb_tag]       <= i_cdb_data;
            ent_mispredict[i_cdb_tag] <= i_cdb_mispredict;
        end
    end

    // Operand lookup with same-cycle CDB bypass.
    always_comb begin
        if (i_cdb_valid && i_cdb_tag == i_rs1_tag) begin
            o_rs1_valid = 1'b1;
            o_rs1_data  = i_cdb_data;
        end else begin
            o_rs1_valid = ent_valid[i_rs1_tag] && ent_done[i_rs1_tag];
            o_rs1_data  = ent_data[i_rs1_tag];
        end
        if (i_cdb_valid && i_cdb_tag == i_rs2_tag) begin
            o_rs2_valid = 1'b1;
            o_rs2_data  = i_cdb_data;
        end else begin
            o_rs2_valid = ent_valid[i_rs2_tag] && ent_done[i_rs2_tag];
            o_rs2_data  = ent_data[i_rs2_tag];
        end
    end

endmodule

// File: tb/tb_rob_mw.sv
// -----------------------------------------------------------------------------
// tb_rob_mw : directed checks of rob_mw (DEPTH 32, RETIRE_W 2)
// Inputs change on the falling edge; outputs are compared 1 ns later.
// -----------------------------------------------------------------------------
module tb_rob_mw;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_disp_en;
    logic [4:0]  i_disp_rd;
    logic [31:0] i_disp_pc;
    logic [1:0]  i_disp_type;
    logic [4:0]  o_disp_tag;
    logic        o_full;
    logic [4:0]  i_rs1_tag;
    logic [4:0]  i_rs2_tag;
    logic        o_rs1_valid;
    logic        o_rs2_valid;
    logic [31:0] o_rs1_data;
    logic [31:0] o_rs2_data;
    logic        i_cdb_valid;
    logic [4:0]  i_cdb_tag;
    logic [31:0] i_cdb_data;
    logic        i_cdb_mispredict;
    logic        i_st_ready;
    logic [1:0]  o_ret_valid;
    logic [9:0]  o_ret_rd;
    logic [63:0] o_ret_data;
    logic [63:0] o_ret_pc;
    logic [3:0]  o_ret_type;
    logic        o_flush;
    logic [5:0]  o_count;

    int checks;
    int errors;

    rob_mw #(.DEPTH(32), .XLEN(32), .RETIRE_W(2)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_disp_en        (i_disp_en),
        .i_disp_rd        (i_disp_rd),
        .i_disp_pc        (i_disp_pc),
        .i_disp_type      (i_disp_type),
        .o_disp_tag       (o_disp_tag),
        .o_full           (o_full),
        .i_rs1_tag        (i_rs1_tag),
        .i_rs2_tag        (i_rs2_tag),
        .o_rs1_valid      (o_rs1_valid),
        .o_rs2_valid      (o_rs2_valid),
        .o_rs1_data       (o_rs1_data),
        .o_rs2_data       (o_rs2_data),
        .i_cdb_valid      (i_cdb_valid),
        .i_cdb_tag        (i_cdb_tag),
        .i_cdb_data       (i_cdb_data),
        .i_cdb_mispredict (i_cdb_mispredict),
        .i_st_ready       (i_st_ready),
        .o_ret_valid      (o_ret_valid),
        .o_ret_rd         (o_ret_rd),
        .o_ret_data       (o_ret_data),
        .o_ret_pc         (o_ret_pc),
        .o_ret_type       (o_ret_type),
        .o_flush          (o_flush),
        .o_count          (o_count)
    );

    // 10 ns clock
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of dispatch and CDB inputs on the falling edge.
    task automatic applyStimulus(input logic disp_en, input logic [4:0] rd, input logic [31:0] pc,
                                 input logic [1:0] typ, input logic cdb_v, input logic [4:0] tag,
                                 input logic [31:0] data, input logic mis);
        @(negedge i_clk);
        i_disp_en        = disp_en;
        i_disp_rd        = rd;
        i_disp_pc        = pc;
        i_disp_type      = typ;
        i_cdb_valid      = cdb_v;
        i_cdb_tag        = tag;
        i_cdb_data       = data;
        i_cdb_mispredict = mis;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'd0, 2'b00, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    // Directed sequence
    initial begin
        checks           = 0;
        errors           = 0;
        i_rst_n          = 1'b1;
        i_disp_en        = 1'b0;
        i_disp_rd        = '0;
        i_disp_pc        = '0;
        i_disp_type      = '0;
        i_rs1_tag        = '0;
        i_rs2_tag        = '0;
        i_cdb_valid      = 1'b0;
        i_cdb_tag        = '0;
        i_cdb_data       = '0;
        i_cdb_mispredict = 1'b0;
        i_st_ready       = 1'b0;

        #2 i_rst_n = 1'b0;
        #1;
        checkOutput("rst_count", o_count, 0);
        checkOutput("rst_full", o_full, 0);
        checkOutput("rst_ret_valid", o_ret_valid, 0);
        checkOutput("rst_flush", o_flush, 0);
        checkOutput("rst_disp_tag", o_disp_tag, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Three ALU dispatches then out-of-order completion
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'(i + 1), 32'h100 + 32'(4 * i), 2'b00, 1'b0, 5'd0, 32'd0, 1'b0);
            checkOutput("alu_disp_tag", o_disp_tag, i);
        end
        idle();
        checkOutput("alu_count3", o_count, 3);
        checkOutput("alu_ret_none", o_ret_valid, 0);
        applyStimulus(1'b0, 5'd0, 32'd0, 2'b00, 1'b1, 5'd1, 32'hAA, 1'b0);
        checkOutput("cdb1_ret_none", o_ret_valid, 0);
        applyStimulus(1'b0, 5'd0, 32'd0, 2'b00, 1'b1, 5'd0, 32'h55, 1'b0);
        checkOutput("cdb0_ret_none", o_ret_valid, 0);
        idle();
        checkOutput("dual_ret_valid", o_ret_valid, 2'b11);
        checkOutput("dual_rd0", o_ret_rd[4:0], 1);
        checkOutput("dual_data0", o_ret_data[31:0], 32'h55);
        checkOutput("dual_pc0", o_ret_pc[31:0], 32'h100);
        checkOutput("dual_rd1", o_ret_rd[9:5], 2);
        checkOutput("dual_data1", o_ret_data[63:32], 32'hAA);
        checkOutput("dual_pc1", o_ret_pc[63:32], 32'h104);
        checkOutput("dual_count", o_count, 3);
        applyStimulus(1'b0, 5'd0, 32'd0, 2'b00, 1'b1, 5'd2, 32'h33, 1'b0);
        checkOutput("after_dual_count", o_count, 1);
        checkOutput("after_dual_ret", o_ret_valid, 0);
        idle();
        checkOutput("single_ret_valid", o_ret_valid, 2'b01);
        checkOutput("single_rd0", o_ret_rd[4:0], 3);
        checkOutput("single_data0", o_ret_data[31:0], 32'h33);
        idle();
        checkOutput("empty_count", o_count, 0);
        checkOutput("empty_disp_tag", o_disp_tag, 3);

        // Fill all 32 entries starting at tag 3; the tail wraps 31 -> 0
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i), 32'h1000 + 32'(4 * i), 2'b00, 1'b0, 5'd0, 32'd0, 1'b0);
            checkOutput("fill_disp_tag", o_disp_tag, (3 + i) % 32);
        end
        applyStimulus(1'b1, 5'd9, 32'h2000, 2'b00, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("full_flag", o_full, 1);
        checkOutput("full_count", o_count, 32);
        checkOutput("full_disp_tag", o_disp_tag, 3);
        applyStimulus(1'b1, 5'd9, 32'h2000, 2'b00, 1'b1, 5'd3, 32'h77, 1'b0);
        checkOutput("full_drop_count", o_count, 32);
        applyStimulus(1'b1, 5'd9, 32'h2000, 2'b00, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("full_ret_valid", o_ret_valid, 2'b01);
        checkOutput("full_ret_data", o_ret_data[31:0], 32'h77);
        checkOutput("full_still_full", o_full, 1);
        idle();
        checkOutput("unfull_count", o_count, 31);
        checkOutput("unfull_flag", o_full, 0);

        // Asynchronous reset with the buffer occupied
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        checkOutput("midrst_count", o_count, 0);
        checkOutput("midrst_full", o_full, 0);
        checkOutput("midrst_disp_tag", o_disp_tag, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Two stores held back by i_st_ready, then one per cycle in lane 0
        applyStimulus(1'b1, 5'd0, 32'h200, 2'b01, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("st_tag0", o_disp_tag, 0);
        applyStimulus(1'b1, 5'd0, 32'h204, 2'b01, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("st_tag1", o_disp_tag, 1);
        applyStimulus(1'b0, 5'd0, 32'd0, 2'b00, 1'b1, 5'd0, 32'hDEAD, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'd0, 2'b00, 1'b1, 5'd1, 32'hBEEF, 1'b0);
        checkOutput("st_blocked", o_ret_valid, 0);
        for (int i = 0; i < 4; i++) begin
            idle();
            checkOutput("st_blocked", o_ret_valid, 0);
        end
        @(negedge i_clk);
        i_st_ready = 1'b1;
        #1;
        checkOutput("st_ret_valid_a", o_ret_valid, 2'b01);
        checkOutput("st_ret_type_a", o_ret_type[1:0], 2'b01);
        checkOutput("st_ret_data_a", o_ret_data[31:0], 32'hDEAD);
        checkOutput("st_ret_pc_a", o_ret_pc[31:0], 32'h200);
        @(negedge i_clk);
        #1;
        checkOutput("st_ret_valid_b", o_ret_valid, 2'b01);
        checkOutput("st_ret_data_b", o_ret_data[31:0], 32'hBEEF);
        checkOutput("st_ret_pc_b", o_ret_pc[31:0], 32'h204);
        @(negedge i_clk);
        i_st_ready = 1'b0;
        #1;
        checkOutput("st_count", o_count, 0);

        // Advance head to tag 5 with three quick ALU ops
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'(10 + i), 32'h300 + 32'(4 * i), 2'b00, 1'b0, 5'd0, 32'd0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 2'b00, 1'b1, 5'(2 + i), 32'h10, 1'b0);
        end
        idle();
        idle();
        checkOutput("pre_br_count", o_count, 0);
        checkOutput("pre_br_tag", o_disp_tag, 5);

        // Mispredicted branch at tag 5 with four younger entries
        applyStimulus(1'b1, 5'd0, 32'h500, 2'b10, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("br_tag", o_disp_tag, 5);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'(20 + i), 32'h504 + 32'(4 * i), 2'b00, 1'b0, 5'd0, 32'd0, 1'b0);
        end
        i_rs1_tag = 5'd7;
        i_rs2_tag = 5'd6;
        applyStimulus(1'b0, 5'd0, 32'd0, 2'b00, 1'b1, 5'd6, 32'h66, 1'b0);
        checkOutput("rs1_pending", o_rs1_valid, 0);
        checkOutput("rs2_bypass_valid", o_rs2_valid, 1);
        checkOutput("rs2_bypass_data", o_rs2_data, 32'h66);
        applyStimulus(1'b0, 5'd0, 32'd0, 2'b00, 1'b1, 5'd7, 32'h1234, 1'b0);
        checkOutput("rs1_bypass_valid", o_rs1_valid, 1);
        checkOutput("rs1_bypass_data", o_rs1_data, 32'h1234);
        checkOutput("rs2_stored_valid", o_rs2_valid, 1);
        checkOutput("rs2_stored_data", o_rs2_data, 32'h66);
        applyStimulus(1'b0, 5'd0, 32'd0, 2'b00, 1'b1, 5'd8, 32'h88, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'd0, 2'b00, 1'b1, 5'd9, 32'h99, 1'b0);
        checkOutput("br_head_wait", o_ret_valid, 0);
        applyStimulus(1'b0, 5'd0, 32'd0, 2'b00, 1'b1, 5'd5, 32'h600, 1'b1);
        checkOutput("br_cdb_ret", o_ret_valid, 0);
        applyStimulus(1'b1, 5'd30, 32'h900, 2'b00, 1'b0, 5'd0, 32'd0, 1'b0);
        checkOutput("br_ret_valid", o_ret_valid, 2'b01);
        checkOutput("br_ret_type", o_ret_type[1:0], 2'b10);
        checkOutput("br_ret_pc", o_ret_pc[31:0], 32'h500);
        checkOutput("br_flush_early", o_flush, 0);
        checkOutput("br_count", o_count, 5);
        idle();
        checkOutput("flush_pulse", o_flush, 1);
        checkOutput("flush_count", o_count, 0);
        checkOutput("flush_ret", o_ret_valid, 0);
        checkOutput("flush_tail", o_disp_tag, 6);
        checkOutput("flush_rs1_gone", o_rs1_valid, 0);
        idle();
        checkOutput("flush_end", o_flush, 0);
        checkOutput("flush_count2", o_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
